// File: rtl/dsp_ctrl_pkg.sv
// Shared types and OPMODE encodings for the DSP48A1 MAC sequencer.
package dsp_ctrl_pkg;

  localparam int unsigned OP_W  = 18;
  localparam int unsigned P_W   = 48;
  localparam int unsigned OPM_W = 8;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [OPM_W-1:0] OPM_LOAD_M  = 8'h01;
  localparam logic [OPM_W-1:0] OPM_ACC_M   = 8'h09;
  localparam logic [OPM_W-1:0] OPM_HOLD    = 8'h08;
  localparam int unsigned      OPM_SUB_BIT = 7;

  // Slice OPMODE for one pipeline slot: load M, accumulate M, or hold P.
  function automatic logic [OPM_W-1:0] opmode_for(input logic valid, input logic first,
                                                  input logic sub);
    logic [OPM_W-1:0] opm;
    opm = OPM_HOLD;
    if (valid) begin
      opm              = first ? OPM_LOAD_M : OPM_ACC_M;
      opm[OPM_SUB_BIT] = sub;
    end
    return opm;
  endfunction

endpackage

// File: rtl/dsp_mac_sequencer_if.sv
// Operand stream and result handshake bundle of the MAC sequencer.
interface dsp_mac_sequencer_if;
  import dsp_ctrl_pkg::*;

  logic            s_valid;
  logic            s_ready;
  logic [OP_W-1:0] s_a;
  logic [OP_W-1:0] s_b;
  logic            res_valid;
  logic            res_ready;
  logic [P_W-1:0]  res_data;

  modport slave  (input  s_valid, s_a, s_b, res_ready,
                  output s_ready, res_valid, res_data);
  modport master (output s_valid, s_a, s_b, res_ready,
                  input  s_ready, res_valid, res_data);
endinterface

// File: rtl/mac_issue_pipe.sv
// Valid/first shift register tracking issued operand pairs through the slice.
module mac_issue_pipe #(
  parameter int unsigned DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic           in_first,
  output logic [DEPTH:0] tap_valid,
  output logic           opm_first,
  output logic           busy
);

  logic [DEPTH:1]   v_q;
  logic [DEPTH-2:0] f;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) v_q <= '0;
    else        v_q <= {v_q[DEPTH-1:1], in_valid};
  end

  // The first flag is only needed up to the stage that feeds the OPMODE register.
  assign f[0] = in_valid & in_first;

  if (DEPTH > 2) begin : g_first
    logic [DEPTH-2:1] f_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) f_q <= '0;
      else        f_q <= f[DEPTH-3:0];
    end
    assign f[DEPTH-2:1] = f_q;
  end

  assign tap_valid = {v_q, in_valid};
  assign opm_first = f[DEPTH-2];
  assign busy      = |v_q;

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Job controller that streams operand pairs into a DSP48A1 slice and returns sum(+/-A*B).
module dsp_mac_sequencer
  import dsp_ctrl_pkg::*;
#(
  parameter int unsigned LEN_W   = 16,
  parameter int unsigned MAC_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              sub,
  output logic              busy,
  dsp_mac_sequencer_if.slave bus,
  output logic [OP_W-1:0]   dsp_a,
  output logic [OP_W-1:0]   dsp_b,
  output logic              dsp_cea,
  output logic              dsp_ceb,
  output logic              dsp_cem,
  output logic              dsp_ceopmode,
  output logic [OPM_W-1:0]  dsp_opmode,
  output logic              dsp_cep,
  input  logic [P_W-1:0]    dsp_p
);

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   cnt_q;
  logic               sub_q, first_q;
  logic [P_W-1:0]     res_q;
  logic [OPM_W-1:0]   opm_q;
  logic               issue;
  logic [MAC_LAT:0]   tap_valid;
  logic               opm_first, pipe_busy;

  assign issue = bus.s_valid & bus.s_ready;

  mac_issue_pipe #(.DEPTH(MAC_LAT)) u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (issue),
    .in_first  (first_q),
    .tap_valid (tap_valid),
    .opm_first (opm_first),
    .busy      (pipe_busy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (len != '0) ? RUN : DONE;
      RUN:     if (issue && cnt_q == LEN_W'(1)) state_d = DRAIN;
      DRAIN:   if (!pipe_busy) state_d = DONE;
      DONE:    if (bus.res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy          = (state_q != IDLE);
    bus.s_ready   = (state_q == RUN) && (cnt_q != '0);
    bus.res_valid = (state_q == DONE);
  end

  // Job bookkeeping, result capture and the registered OPMODE (slice registers it once more).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      sub_q   <= 1'b0;
      first_q <= 1'b0;
      res_q   <= '0;
      opm_q   <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        cnt_q   <= len;
        sub_q   <= sub;
        first_q <= 1'b1;
        if (len == '0) res_q <= '0;
      end
      if (issue) begin
        cnt_q   <= cnt_q - LEN_W'(1);
        first_q <= 1'b0;
      end
      if (state_q == DRAIN && !pipe_busy) res_q <= dsp_p;
      opm_q <= opmode_for(tap_valid[MAC_LAT-2], opm_first, sub_q);
    end
  end

  assign bus.res_data = res_q;
  assign dsp_a        = bus.s_a;
  assign dsp_b        = bus.s_b;
  assign dsp_cea      = issue;
  assign dsp_ceb      = issue;
  assign dsp_cem      = tap_valid[MAC_LAT-1];
  assign dsp_cep      = tap_valid[MAC_LAT];
  assign dsp_ceopmode = 1'b1;
  assign dsp_opmode   = opm_q;

endmodule
